// File: rtl/cdc_bus_rx_controller.sv
// cdc_bus_rx_controller: 4-phase req/ack receiver with two-flop request synchronizer and one-word output register
module cdc_bus_rx_controller #(
  parameter int WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 async_req,
  input  logic [WIDTH-1:0]     async_data,
  output logic                 ack,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 busy
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_n;
  logic req_meta, req_sync, slot_free, capture;
  assign slot_free = !out_valid || out_ready;
  assign busy = (state != IDLE) || req_sync;
  assign ack = state == ACK;
  // two-flop synchronizer for the request; data is sampled only under the stable-hold protocol
  always_ff @(posedge clk) begin
    if (rst) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= async_req;
      req_sync <= req_meta;
    end
  end
  // state register; ack is decoded from it so it stays a clean registered signal
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // capture once per request high phase, and only when the output slot can take the word
  always_comb begin
    capture = (state == IDLE) && req_sync && slot_free;
    state_n = (capture || (state == ACK && req_sync)) ? ACK : IDLE;
  end
  // output word register and transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      xfer_count <= '0;
    end else if (capture) begin
      out_data   <= async_data;
      out_valid  <= 1'b1;
      xfer_count <= xfer_count + CNT_WIDTH'(1);
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdc_bus_rx_controller.sv
// tb_cdc_bus_rx_controller: directed checks plus a randomized scoreboard run of the req/ack receiver
module tb_cdc_bus_rx_controller;
  localparam int W = 8;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst, async_req, out_ready, ack, out_valid, busy;
  logic [W-1:0] async_data, out_data;
  logic [CW-1:0] xfer_count;
  int total = 0;
  int bad = 0;
  bit sb_on = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  cdc_bus_rx_controller #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .async_req(async_req), .async_data(async_data),
    .ack(ack), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count), .busy(busy)
  );

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // consumer-side scoreboard: every accepted word must be the oldest one sent
  always @(negedge clk) begin
    if (sb_on && out_valid && out_ready) begin
      chk("sb_word_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // 1: reset with request high
    rst = 1; async_req = 1; async_data = '0; out_ready = 1;
    tick(2);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_count", 32'(xfer_count), 0);
    chk("rst_busy", 32'(busy), 0);
    async_req = 0;
    tick();
    rst = 0;
    tick(3);
    // 2: single transfer latency
    async_data = 8'hA5; async_req = 1;
    tick(2);
    chk("t2_busy_e1", 32'(busy), 1);
    chk("t2_valid_e1", 32'(out_valid), 0);
    tick();
    chk("t2_valid_e2", 32'(out_valid), 1);
    chk("t2_data_e2", 32'(out_data), 32'h A5);
    chk("t2_ack_e2", 32'(ack), 1);
    chk("t2_count", 32'(xfer_count), 1);
    tick();
    chk("t2_valid_e3", 32'(out_valid), 0);
    tick(2);
    async_req = 0;
    tick(2);
    chk("t2_ack_e7", 32'(ack), 1);
    tick();
    chk("t2_ack_e8", 32'(ack), 0);
    chk("t2_busy_e8", 32'(busy), 0);
    // 3: back-pressure then simultaneous consume and capture
    out_ready = 0; async_data = 8'h11; async_req = 1;
    tick(3);
    chk("t3_data11", 32'(out_data), 32'h11);
    chk("t3_ack11", 32'(ack), 1);
    async_req = 0;
    tick(3);
    chk("t3_ack11_low", 32'(ack), 0);
    async_data = 8'h22; async_req = 1;
    tick(4);
    chk("t3_ack_withheld", 32'(ack), 0);
    chk("t3_data_held", 32'(out_data), 32'h11);
    chk("t3_valid_held", 32'(out_valid), 1);
    chk("t3_busy", 32'(busy), 1);
    out_ready = 1;
    tick();
    chk("t3_data22", 32'(out_data), 32'h22);
    chk("t3_valid_kept", 32'(out_valid), 1);
    chk("t3_ack22", 32'(ack), 1);
    chk("t3_count", 32'(xfer_count), 3);
    tick();
    chk("t3_consumed", 32'(out_valid), 0);
    async_req = 0;
    tick(3);
    chk("t3_ack_end", 32'(ack), 0);
    // 4: long request gives exactly one capture
    async_data = 8'h5C; async_req = 1;
    tick(3);
    for (int i = 0; i < 47; i++) begin
      tick();
      chk("t4_ack_held", 32'(ack), 1);
    end
    chk("t4_count", 32'(xfer_count), 4);
    async_req = 0;
    tick(2);
    chk("t4_ack_e2", 32'(ack), 1);
    tick();
    chk("t4_ack_e3", 32'(ack), 0);
    chk("t4_count_end", 32'(xfer_count), 4);
    // 5: randomized transfers against a scoreboard; count wraps at 8 bits
    rst = 1;
    tick();
    rst = 0;
    sb_on = 1;
    for (int t = 0; t < 300; t++) begin
      async_data = W'($urandom);
      exp_q.push_back(async_data);
      async_req = 1;
      for (int k = 0; k < 200 && !ack; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("t5_ack_rise", 32'(ack), 1);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      async_req = 0;
      for (int k = 0; k < 20 && ack; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("t5_ack_fall", 32'(ack), 0);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    out_ready = 1;
    tick(3);
    sb_on = 0;
    chk("t5_drained", 32'(exp_q.size()), 0);
    chk("t5_count_wrap", 32'(xfer_count), 44);
    // 6: reset while acknowledging, then recapture after release
    out_ready = 0; async_data = 8'h3E; async_req = 1;
    tick(3);
    chk("t6_ack_pre", 32'(ack), 1);
    chk("t6_valid_pre", 32'(out_valid), 1);
    rst = 1;
    tick();
    chk("t6_ack_rst", 32'(ack), 0);
    chk("t6_valid_rst", 32'(out_valid), 0);
    chk("t6_data_rst", 32'(out_data), 0);
    rst = 0;
    tick(2);
    chk("t6_valid_e1", 32'(out_valid), 0);
    tick();
    chk("t6_valid_e2", 32'(out_valid), 1);
    chk("t6_ack_e2", 32'(ack), 1);
    chk("t6_data_e2", 32'(out_data), 32'h3E);
    chk("t6_count", 32'(xfer_count), 1);
    async_req = 0;
    tick(3);
    chk("t6_ack_end", 32'(ack), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
